// File: rtl/serial_add_sched.sv
// Two-requester round-robin front end for a shared LSB-first serial adder.
// Grants one requester, steps WIDTH add cycles, then pulses done with the result.
module serial_add_sched #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             c_in0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             c_in1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic [WIDTH-1:0] i,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             done,
    output logic             done_id
);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] i_q, i_d;
    logic             carry_q, carry_d;
    logic             c_out_q, c_out_d;
    logic             done_q, done_d;
    logic             done_id_q, done_id_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;

    logic sum_bit;
    logic carry_nxt;
    logic win;

    assign sum_bit   = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    assign carry_nxt = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
    // On a tie the requester that did not win last time is served.
    assign win       = (req0 && req1) ? ~last_q : req1;

    always_comb begin
        state_d   = state_q;
        a_sr_d    = a_sr_q;
        b_sr_d    = b_sr_q;
        s_d       = s_q;
        i_d       = i_q;
        carry_d   = carry_q;
        c_out_d   = c_out_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        owner_d   = owner_q;
        last_d    = last_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = ADD;
                    a_sr_d  = win ? a1 : a0;
                    b_sr_d  = win ? b1 : b0;
                    carry_d = win ? c_in1 : c_in0;
                    s_d     = '0;
                    i_d     = {{(WIDTH-1){1'b0}}, 1'b1};
                    owner_d = win;
                    last_d  = win;
                    gnt0_d  = ~win;
                    gnt1_d  = win;
                end
            end
            ADD: begin
                s_d     = {sum_bit, s_q[WIDTH-1:1]};
                carry_d = carry_nxt;
                a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
                i_d     = {i_q[WIDTH-2:0], 1'b0};
                if (i_q[WIDTH-1]) begin
                    i_d       = '0;
                    c_out_d   = carry_nxt;
                    done_d    = 1'b1;
                    done_id_d = owner_q;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_sr_q    <= '0;
            b_sr_q    <= '0;
            s_q       <= '0;
            i_q       <= '0;
            carry_q   <= 1'b0;
            c_out_q   <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sr_q    <= a_sr_d;
            b_sr_q    <= b_sr_d;
            s_q       <= s_d;
            i_q       <= i_d;
            carry_q   <= carry_d;
            c_out_q   <= c_out_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
        end
    end

    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign busy    = (state_q != IDLE);
    assign i       = i_q;
    assign s       = s_q;
    assign c_out   = c_out_q;
    assign done    = done_q;
    assign done_id = done_id_q;

endmodule

// File: tb/tb_serial_add_sched.sv
// Randomized and directed checks of serial_add_sched against an arithmetic /
// round-robin reference model held in the bench.
module tb_serial_add_sched;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic         c_in0 = 1'b0, c_in1 = 1'b0;
    logic         gnt0, gnt1, busy, c_out, done, done_id;
    logic [W-1:0] i, s;

    int n_cmp = 0;
    int n_err = 0;
    int ptr = 1;
    int first_gnt = -1;

    always #5 clk = ~clk;

    serial_add_sched #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .c_in0(c_in0),
        .req1(req1), .a1(a1), .b1(b1), .c_in1(c_in1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .i(i), .s(s),
        .c_out(c_out), .done(done), .done_id(done_id)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, int'({gnt1, gnt0}), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_i"}, int'(i), 0);
        check({tag, "_res"}, int'({c_out, s}), 0);
        check({tag, "_done"}, int'({done_id, done}), 0);
    endtask

    // Serves requests until n_done results have been observed. The model
    // predicts the grant winner, the one-hot bit position, and a+b+c_in.
    task automatic run_until(input int n_done, input bit hold, input bit disturb);
        int budget, cyc, gnt_cyc, last_done, k, win, left, exp_res, exp_id;
        bit in_flight;
        budget = 300; cyc = 0; gnt_cyc = 0; last_done = -1; left = n_done;
        in_flight = 0; exp_res = 0; exp_id = 0; first_gnt = -1;
        while (left > 0 && budget > 0) begin
            @(negedge clk);
            cyc++; budget--;
            if (gnt0 || gnt1) begin
                check("gnt_while_busy", int'(in_flight), 0);
                win = (req0 && req1) ? 1 - ptr : (req1 ? 1 : 0);
                check("gnt0", int'(gnt0), int'(win == 0));
                check("gnt1", int'(gnt1), int'(win == 1));
                ptr = win;
                exp_res = win ? int'(a1) + int'(b1) + int'(c_in1)
                              : int'(a0) + int'(b0) + int'(c_in0);
                exp_id = win;
                if (first_gnt < 0) first_gnt = cyc;
                in_flight = 1;
                gnt_cyc = cyc;
                if (!hold) begin
                    if (win == 0) req0 = 1'b0;
                    else          req1 = 1'b0;
                end
            end
            if (in_flight) begin
                k = cyc - gnt_cyc;
                check("busy_op", int'(busy), 1);
                check("i_pos", int'(i), (k < W) ? (1 << k) : 0);
                check("done_pulse", int'(done), int'(k == W));
                if (k == W) begin
                    check("result", int'({c_out, s}), exp_res);
                    check("done_id", int'(done_id), exp_id);
                    if (hold && last_done >= 0) check("done_spacing", cyc - last_done, W + 2);
                    last_done = cyc;
                    in_flight = 0;
                    left--;
                    if (left == 0) begin
                        req0 = 1'b0;
                        req1 = 1'b0;
                    end
                end else if (disturb) begin
                    a0 = W'($urandom);
                    b0 = W'($urandom);
                    req1 = 1'($urandom_range(0, 1));
                end
            end else begin
                check("busy_idle", int'(busy), 0);
                check("done_idle", int'(done), 0);
                check("i_idle", int'(i), 0);
            end
        end
        if (left > 0) check("timeout_results_left", left, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        ptr = 1;
    endtask

    initial begin
        int pat, t;
        #3;
        check_all_zero("por");
        @(negedge clk);
        rst = 1'b0;

        // Single requester: 11 + 6 + 1 = 18 -> s=2, c_out=1
        a0 = 4'd11; b0 = 4'd6; c_in0 = 1'b1; req0 = 1'b1;
        run_until(1, 0, 0);
        check("lat_gnt_cycles", first_gnt, 1);
        check("dir_sum", int'({c_out, s}), 18);
        check("dir_id", int'(done_id), 0);
        @(negedge clk);
        check("hold_after_done", int'({c_out, s}), 18);

        // Tie straight after reset: requester 0 first, then 1
        do_reset();
        a0 = 4'd3;  b0 = 4'd4;  c_in0 = 1'b0;
        a1 = 4'd15; b1 = 4'd15; c_in1 = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        run_until(2, 0, 0);
        check("tie_last_id", int'(done_id), 1);
        check("tie_last_res", int'({c_out, s}), 31);

        // Reset in the middle of ADD
        @(negedge clk);
        @(negedge clk);
        a0 = 4'd9; b0 = 4'd9; c_in0 = 1'b1; req0 = 1'b1;
        t = 0;
        while (!gnt0 && t < 10) begin
            @(negedge clk);
            t++;
        end
        check("mid_rst_gnt_seen", int'(gnt0), 1);
        req0 = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_all_zero("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        ptr = 1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check("no_done_after_rst", int'({busy, done}), 0);
        end
        a0 = 4'd5; b0 = 4'd10; c_in0 = 1'b0; req0 = 1'b1;
        run_until(1, 0, 0);

        // Continuous contention: alternating grants, results every W+2 cycles
        a0 = 4'd7; b0 = 4'd8; c_in0 = 1'b1;
        a1 = 4'd2; b1 = 4'd12; c_in1 = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        run_until(6, 1, 0);

        // Operand / request disturbance during ADD
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            a0 = W'($urandom); b0 = W'($urandom); c_in0 = 1'($urandom);
            req0 = 1'b1;
            run_until(1, 0, 1);
        end

        // Random request patterns
        for (int n = 0; n < 60; n++) begin
            pat = $urandom_range(1, 3);
            a0 = W'($urandom); b0 = W'($urandom); c_in0 = 1'($urandom);
            a1 = W'($urandom); b1 = W'($urandom); c_in1 = 1'($urandom);
            req0 = pat[0];
            req1 = pat[1];
            run_until((pat == 3) ? 2 : 1, 0, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Exhaustive arithmetic through requester 1
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++) begin
                    a1 = W'(a); b1 = W'(b); c_in1 = 1'(c);
                    req1 = 1'b1;
                    run_until(1, 0, 0);
                end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
